ram64_8: RTL and testbench

- 64-word × 8-bit random-access memory for the CPU datapath.
- Synchronous write on the rising clock edge; combinational (asynchronous) read.
- Built as eight 8-word banks, in the same hierarchical style as the rest of the memory hierarchy.
- Holds program and data words addressed by the CPU address bus.

---
 rtl/ram64_8_pkg.sv | 20 ++
 rtl/ram64_8_ram8_8.sv | 38 +++
 rtl/ram64_8.sv | 57 +++++
 tb/tb_ram64_8.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/ram64_8_pkg.sv
// ============================================================================
// Module  : ram64_8_pkg
// Purpose : Shared widths for the 64x8 RAM and its 8x8 banks.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram64_8_pkg;
  // Data and address bus width of the CPU datapath
  localparam int WORDSIZE  = 8;
  // Address bits decoded by the 64-word RAM
  localparam int RAM64_AW  = 6;
  // Address bits decoded inside one 8-word bank
  localparam int RAM8_AW   = 3;
  // Address bits used to pick a bank
  localparam int BANK_AW   = RAM64_AW - RAM8_AW;
  localparam int BANK_WORDS = 1 << RAM8_AW;
endpackage : ram64_8_pkg

`default_nettype wire

// File: rtl/ram64_8_ram8_8.sv
// ============================================================================
// Module  : ram8_8
// Purpose : 8-word x 8-bit bank. Synchronous write, combinational read,
//           asynchronous active-low clear of every word.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram8_8
  import ram64_8_pkg::*;
(
  input  logic                clk,
  input  logic                clr_n,
  input  logic [WORDSIZE-1:0] data_in,
  input  logic [RAM8_AW-1:0]  addr,
  input  logic                write_en,
  output logic [WORDSIZE-1:0] data_out
);

  logic [WORDSIZE-1:0] mem_q [BANK_WORDS];

  // Word storage: cleared while clr_n is low, otherwise one word per enabled edge
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int i = 0; i < BANK_WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (write_en) begin
      mem_q[addr] <= data_in;
    end
  end

  // Zero-latency read of the addressed word, no write bypass
  assign data_out = mem_q[addr];

endmodule : ram8_8

`default_nettype wire

// File: rtl/ram64_8.sv
// ============================================================================
// Module  : ram64_8
// Purpose : 64-word x 8-bit RAM built from eight ram8_8 banks. addr[5:3]
//           selects the bank, addr[2:0] the word; addr[7:6] alias.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram64_8
  import ram64_8_pkg::*;
#(
  parameter int WORDSIZE_P = WORDSIZE,
  parameter int DEPTH      = 64
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic [WORDSIZE_P-1:0] data_in,
  input  logic [WORDSIZE_P-1:0] addr,
  input  logic                  write_en,
  output logic [WORDSIZE_P-1:0] data_out
);

  localparam int NUM_BANKS = DEPTH / BANK_WORDS;

  logic [BANK_AW-1:0]    bank_sel;
  logic [RAM8_AW-1:0]    word_sel;
  logic [NUM_BANKS-1:0]  bank_we;
  logic [WORDSIZE-1:0]   bank_out [NUM_BANKS];
  logic                  unused_addr_hi;

  assign word_sel = addr[RAM8_AW-1:0];
  assign bank_sel = addr[RAM64_AW-1:RAM8_AW];
  // Upper address bits are deliberately ignored so addresses wrap every 64 words
  assign unused_addr_hi = ^addr[WORDSIZE_P-1:RAM64_AW];

  generate
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      // One-hot bank write enable
      assign bank_we[b] = write_en & (bank_sel == BANK_AW'(b));

      ram8_8 u_bank (
        .clk      (clk),
        .clr_n    (clr_n),
        .data_in  (data_in),
        .addr     (word_sel),
        .write_en (bank_we[b]),
        .data_out (bank_out[b])
      );
    end
  endgenerate

  // 8:1 output mux of the bank read ports
  assign data_out = bank_out[bank_sel];

endmodule : ram64_8

`default_nettype wire

// File: tb/tb_ram64_8.sv
// ============================================================================
// Module  : tb_ram64_8
// Purpose : Directed self-checking bench for ram64_8.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram64_8;

  logic       clk;
  logic       clr_n;
  logic [7:0] data_in;
  logic [7:0] addr;
  logic       write_en;
  logic [7:0] data_out;

  int n_tests;
  int n_fail;

  ram64_8 dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .data_in  (data_in),
    .addr     (addr),
    .write_en (write_en),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write one word: drive on falling edge, commit on rising edge
  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    addr     = a;
    data_in  = d;
    write_en = 1'b1;
    @(posedge clk);
    #1;
    write_en = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] addrs [4];
    addrs[0] = 8'd0; addrs[1] = 8'd7; addrs[2] = 8'd8; addrs[3] = 8'd63;
    #3;
    for (int i = 0; i < 4; i++) begin
      addr = addrs[i];
      #1;
      n_tests++;
      if (data_out !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_read addr=%0d got=%h exp=00", addrs[i], data_out);
      end
    end
    clr_n = 1'b1;
    #2;
  endtask

  task automatic test_sequential();
    logic [7:0] vals [4];
    vals[0] = 8'd10; vals[1] = 8'd12; vals[2] = 8'd2; vals[3] = 8'd3;
    // Read-during-write: old value before the edge, new value after
    @(negedge clk);
    addr = 8'd0; data_in = vals[0]; write_en = 1'b1;
    #1;
    n_tests++;
    if (data_out !== 8'h00) begin
      n_fail++;
      $display("FAIL rdw_before got=%h exp=00", data_out);
    end
    @(posedge clk);
    #1;
    write_en = 1'b0;
    n_tests++;
    if (data_out !== vals[0]) begin
      n_fail++;
      $display("FAIL rdw_after got=%h exp=%h", data_out, vals[0]);
    end
    for (int i = 1; i < 4; i++) do_write(8'(i), vals[i]);
    // Combinational sweep with no write edges
    for (int i = 0; i < 4; i++) begin
      addr = 8'(i);
      #1;
      n_tests++;
      if (data_out !== vals[i]) begin
        n_fail++;
        $display("FAIL seq_read addr=%0d got=%h exp=%h", i, data_out, vals[i]);
      end
    end
  endtask

  task automatic test_write_disabled();
    @(negedge clk);
    addr = 8'd1; data_in = 8'd99; write_en = 1'b0;
    @(posedge clk);
    #1;
    n_tests++;
    if (data_out !== 8'd12) begin
      n_fail++;
      $display("FAIL write_disabled got=%0d exp=12", data_out);
    end
  endtask

  task automatic test_bank_boundaries();
    logic [7:0] a [6];
    logic [7:0] e [6];
    do_write(8'd7,  8'h77);
    do_write(8'd8,  8'h88);
    do_write(8'd63, 8'hFF);
    a[0] = 8'd7;  e[0] = 8'h77;
    a[1] = 8'd8;  e[1] = 8'h88;
    a[2] = 8'd63; e[2] = 8'hFF;
    a[3] = 8'd6;  e[3] = 8'h00;
    a[4] = 8'd9;  e[4] = 8'h00;
    a[5] = 8'd62; e[5] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      addr = a[i];
      #1;
      n_tests++;
      if (data_out !== e[i]) begin
        n_fail++;
        $display("FAIL bank_boundary addr=%0d got=%h exp=%h", a[i], data_out, e[i]);
      end
    end
  endtask

  task automatic test_aliasing();
    do_write(8'h40, 8'h5A);
    addr = 8'd0;
    #1;
    n_tests++;
    if (data_out !== 8'h5A) begin
      n_fail++;
      $display("FAIL alias_0 got=%h exp=5a", data_out);
    end
    addr = 8'd255;
    #1;
    n_tests++;
    if (data_out !== 8'hFF) begin
      n_fail++;
      $display("FAIL alias_255 got=%h exp=ff", data_out);
    end
    addr = 8'd1;
    #1;
    n_tests++;
    if (data_out !== 8'd12) begin
      n_fail++;
      $display("FAIL alias_word1 got=%h exp=0c", data_out);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] exp;
    // Drop reset between edges while a write is being set up
    @(negedge clk);
    addr = 8'd1; data_in = 8'hEE; write_en = 1'b1;
    #1;
    clr_n = 1'b0;
    #1;
    n_tests++;
    if (data_out !== 8'h00) begin
      n_fail++;
      $display("FAIL async_clear got=%h exp=00", data_out);
    end
    // Edge while in reset writes nothing
    @(posedge clk);
    #1;
    n_tests++;
    if (data_out !== 8'h00) begin
      n_fail++;
      $display("FAIL write_in_reset got=%h exp=00", data_out);
    end
    write_en = 1'b0;
    clr_n = 1'b1;
    do_write(8'd2, 8'h33);
    for (int i = 0; i < 64; i++) begin
      addr = 8'(i);
      exp  = (i == 2) ? 8'h33 : 8'h00;
      #1;
      n_tests++;
      if (data_out !== exp) begin
        n_fail++;
        $display("FAIL post_reset addr=%0d got=%h exp=%h", i, data_out, exp);
      end
    end
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    clr_n    = 1'b0;
    data_in  = 8'h00;
    addr     = 8'h00;
    write_en = 1'b0;
    test_reset();
    test_sequential();
    test_write_disabled();
    test_bank_boundaries();
    test_aliasing();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_ram64_8

`default_nettype wire
